// File: rtl/axi_trk_pkg.sv
// Shared types for the AXI slave transaction tracker: event kinds, the
// completion record carried through the event queue, and error bit indices.
package axi_trk_pkg;

  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_WR_DONE = 2'd1,
    EV_RD_DONE = 2'd2
  } ev_kind_e;

  // Record fields are sized for the widest supported port; the top
  // zero-extends into them and slices back out on the way to the ports.
  localparam int unsigned REC_ID_W   = 16;
  localparam int unsigned REC_ADDR_W = 64;

  typedef struct packed {
    ev_kind_e              kind;
    logic [REC_ID_W-1:0]   id;
    logic [REC_ADDR_W-1:0] addr;
    logic [8:0]            beats;
    logic [1:0]            resp;
  } ev_rec_t;

  localparam int unsigned ERR_W_LAST  = 0;
  localparam int unsigned ERR_W_NO_AW = 1;
  localparam int unsigned ERR_B_BAD   = 2;
  localparam int unsigned ERR_R_ID    = 3;
  localparam int unsigned ERR_R_LAST  = 4;
  localparam int unsigned ERR_OVF     = 5;
  localparam int unsigned ERR_W       = 6;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_trk_evq.sv
// Completion event FIFO with two push ports (port 0 takes the first free
// slot) and one pop port. A push that finds no room is dropped and flagged.
module axi_trk_evq
  import axi_trk_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push0_i,
  input  ev_rec_t rec0_i,
  input  logic    push1_i,
  input  ev_rec_t rec1_i,
  input  logic    pop_i,
  output logic    valid_o,
  output ev_rec_t rec_o,
  output logic    drop0_o,
  output logic    drop1_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  ev_rec_t       mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, wptr1;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW:0]   avail;
  logic          pop_en, acc0, acc1;

  // Slot accounting: a same-cycle pop frees its slot for an incoming push.
  always_comb begin
    pop_en  = (cnt_q != '0) && pop_i;
    avail   = (PW+1)'(DEPTH) - cnt_q + (PW+1)'(pop_en);
    acc0    = push0_i && (avail != '0);
    acc1    = push1_i && (acc0 ? (avail >= (PW+1)'(2)) : (avail != '0));
    drop0_o = push0_i && !acc0;
    drop1_o = push1_i && !acc1;
    wptr1   = acc0 ? wptr_q + PW'(1) : wptr_q;
    wptr_d  = wptr1 + PW'(acc1);
    rptr_d  = rptr_q + PW'(pop_en);
    cnt_d   = cnt_q + (PW+1)'(acc0) + (PW+1)'(acc1) - (PW+1)'(pop_en);
    valid_o = (cnt_q != '0);
    rec_o   = valid_o ? mem_q[rptr_q] : '0;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Record storage; contents are only visible through a valid pointer.
  always_ff @(posedge clk) begin
    if (acc0) mem_q[wptr_q] <= rec0_i;
    if (acc1) mem_q[wptr1]  <= rec1_i;
  end

endmodule

// File: rtl/axi_slave_txn_tracker.sv
// Passive AXI4 slave-port tracker: pairs AW/W/B and AR/R on handshakes,
// checks beat counts, last flags and IDs, and queues one record per burst.
module axi_slave_txn_tracker
  import axi_trk_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned EVQ_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  aw_valid_i,
  input  logic                  aw_ready_i,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]            aw_len_i,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic                  w_valid_i,
  input  logic                  w_ready_i,
  input  logic                  w_last_i,
  input  logic                  b_valid_i,
  input  logic                  b_ready_i,
  input  logic [ID_WIDTH-1:0]   b_id_i,
  input  logic [1:0]            b_resp_i,
  input  logic                  ar_valid_i,
  input  logic                  ar_ready_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic                  r_valid_i,
  input  logic                  r_ready_i,
  input  logic                  r_last_i,
  input  logic [ID_WIDTH-1:0]   r_id_i,
  input  logic [1:0]            r_resp_i,
  output logic                  ev_valid_o,
  input  logic                  ev_ready_i,
  output logic [1:0]            ev_kind_o,
  output logic [ID_WIDTH-1:0]   ev_id_o,
  output logic [ADDR_WIDTH-1:0] ev_addr_o,
  output logic [8:0]            ev_beats_o,
  output logic [1:0]            ev_resp_o,
  output logic [5:0]            err_o,
  output logic [15:0]           wr_cnt_o,
  output logic [15:0]           rd_cnt_o
);

  localparam int unsigned PW = $clog2(OUTSTANDING);
  typedef logic [PW:0] ptr_t;

  logic [ID_WIDTH-1:0]   aw_id_q   [OUTSTANDING];
  logic [ADDR_WIDTH-1:0] aw_addr_q [OUTSTANDING];
  logic [7:0]            aw_len_q  [OUTSTANDING];
  logic [ID_WIDTH-1:0]   ar_id_q   [OUTSTANDING];
  logic [ADDR_WIDTH-1:0] ar_addr_q [OUTSTANDING];
  logic [7:0]            ar_len_q  [OUTSTANDING];

  ptr_t aw_push_q, aw_push_d, aw_w_q, aw_w_d, aw_b_q, aw_b_d;
  ptr_t ar_push_q, ar_push_d, ar_head_q, ar_head_d;

  logic [7:0]       w_beat_q, w_beat_d, r_beat_q, r_beat_d;
  logic [1:0]       r_resp_q, r_resp_d;
  logic [ERR_W-1:0] err_q, err_d, err_set;
  logic [15:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          aw_we, ar_we, b_pop, w_last_exp, r_last_exp;
  logic          aw_full, ar_full;
  logic [PW-1:0] aw_pi, aw_wi, aw_bi, ar_pi, ar_hi;
  logic          wr_ev, rd_ev, drop0, drop1;
  ev_rec_t       wr_rec, rd_rec, head_rec;
  logic          unused_rec_bits;

  // Handshake decode, queue pointer/beat tracking and record assembly.
  always_comb begin
    aw_hs = aw_valid_i && aw_ready_i;
    w_hs  = w_valid_i  && w_ready_i;
    b_hs  = b_valid_i  && b_ready_i;
    ar_hs = ar_valid_i && ar_ready_i;
    r_hs  = r_valid_i  && r_ready_i;

    aw_pi = aw_push_q[PW-1:0];
    aw_wi = aw_w_q[PW-1:0];
    aw_bi = aw_b_q[PW-1:0];
    ar_pi = ar_push_q[PW-1:0];
    ar_hi = ar_head_q[PW-1:0];

    aw_full = (ptr_t'(aw_push_q - aw_b_q) == ptr_t'(OUTSTANDING));
    ar_full = (ptr_t'(ar_push_q - ar_head_q) == ptr_t'(OUTSTANDING));

    aw_push_d  = aw_push_q;
    aw_w_d     = aw_w_q;
    aw_b_d     = aw_b_q;
    ar_push_d  = ar_push_q;
    ar_head_d  = ar_head_q;
    w_beat_d   = w_beat_q;
    r_beat_d   = r_beat_q;
    r_resp_d   = r_resp_q;
    err_set    = '0;
    aw_we      = 1'b0;
    ar_we      = 1'b0;
    b_pop      = 1'b0;
    wr_ev      = 1'b0;
    rd_ev      = 1'b0;
    wr_rec     = '0;
    rd_rec     = '0;
    w_last_exp = 1'b0;
    r_last_exp = 1'b0;

    if (b_hs) begin
      if (aw_b_q == aw_push_q) begin
        err_set[ERR_B_BAD] = 1'b1;
      end else begin
        if ((aw_b_q == aw_w_q) || (b_id_i != aw_id_q[aw_bi])) err_set[ERR_B_BAD] = 1'b1;
        b_pop                         = 1'b1;
        aw_b_d                        = aw_b_q + ptr_t'(1);
        wr_ev                         = 1'b1;
        wr_rec.kind                   = EV_WR_DONE;
        wr_rec.id[ID_WIDTH-1:0]       = aw_id_q[aw_bi];
        wr_rec.addr[ADDR_WIDTH-1:0]   = aw_addr_q[aw_bi];
        wr_rec.beats                  = {1'b0, aw_len_q[aw_bi]} + 9'd1;
        wr_rec.resp                   = b_resp_i;
      end
    end

    if (w_hs) begin
      if (aw_w_q == aw_push_q) begin
        err_set[ERR_W_NO_AW] = 1'b1;
      end else begin
        w_last_exp = (w_beat_q == aw_len_q[aw_wi]);
        if (w_last_i != w_last_exp) err_set[ERR_W_LAST] = 1'b1;
        if (w_last_exp) begin
          aw_w_d   = aw_w_q + ptr_t'(1);
          w_beat_d = '0;
        end else begin
          w_beat_d = w_beat_q + 8'd1;
        end
      end
    end

    // A B that pops an entry whose data never finished drags the W owner
    // past it, so the W pointer can never trail the B pointer.
    if (b_pop && (aw_b_q == aw_w_q)) begin
      aw_w_d   = aw_b_q + ptr_t'(1);
      w_beat_d = '0;
    end

    if (aw_hs) begin
      if (aw_full && !b_pop) begin
        err_set[ERR_OVF] = 1'b1;
      end else begin
        aw_we     = 1'b1;
        aw_push_d = aw_push_q + ptr_t'(1);
      end
    end

    if (r_hs) begin
      if (ar_head_q == ar_push_q) begin
        err_set[ERR_R_ID] = 1'b1;
      end else begin
        if (r_id_i != ar_id_q[ar_hi]) err_set[ERR_R_ID] = 1'b1;
        r_last_exp = (r_beat_q == ar_len_q[ar_hi]);
        if (r_last_i != r_last_exp) err_set[ERR_R_LAST] = 1'b1;
        if (r_last_exp) begin
          rd_ev                       = 1'b1;
          rd_rec.kind                 = EV_RD_DONE;
          rd_rec.id[ID_WIDTH-1:0]     = ar_id_q[ar_hi];
          rd_rec.addr[ADDR_WIDTH-1:0] = ar_addr_q[ar_hi];
          rd_rec.beats                = {1'b0, ar_len_q[ar_hi]} + 9'd1;
          rd_rec.resp                 = resp_max(r_resp_q, r_resp_i);
          ar_head_d                   = ar_head_q + ptr_t'(1);
          r_beat_d                    = '0;
          r_resp_d                    = '0;
        end else begin
          r_beat_d = r_beat_q + 8'd1;
          r_resp_d = resp_max(r_resp_q, r_resp_i);
        end
      end
    end

    if (ar_hs) begin
      if (ar_full && !rd_ev) begin
        err_set[ERR_OVF] = 1'b1;
      end else begin
        ar_we     = 1'b1;
        ar_push_d = ar_push_q + ptr_t'(1);
      end
    end
  end

  // Sticky errors and saturating completion counters; clear wins.
  always_comb begin
    err_d    = err_q | err_set;
    err_d[ERR_OVF] = err_d[ERR_OVF] | drop0 | drop1;
    wr_cnt_d = (wr_ev && (wr_cnt_q != 16'hFFFF)) ? wr_cnt_q + 16'd1 : wr_cnt_q;
    rd_cnt_d = (rd_ev && (rd_cnt_q != 16'hFFFF)) ? rd_cnt_q + 16'd1 : rd_cnt_q;
    if (clear_i) begin
      err_d    = '0;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end
  end

  // Tracking state registers, discarded asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_push_q <= '0;
      aw_w_q    <= '0;
      aw_b_q    <= '0;
      ar_push_q <= '0;
      ar_head_q <= '0;
      w_beat_q  <= '0;
      r_beat_q  <= '0;
      r_resp_q  <= '0;
      err_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      aw_push_q <= aw_push_d;
      aw_w_q    <= aw_w_d;
      aw_b_q    <= aw_b_d;
      ar_push_q <= ar_push_d;
      ar_head_q <= ar_head_d;
      w_beat_q  <= w_beat_d;
      r_beat_q  <= r_beat_d;
      r_resp_q  <= r_resp_d;
      err_q     <= err_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Address-phase storage for both queues; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (aw_we) begin
      aw_id_q[aw_pi]   <= aw_id_i;
      aw_addr_q[aw_pi] <= aw_addr_i;
      aw_len_q[aw_pi]  <= aw_len_i;
    end
    if (ar_we) begin
      ar_id_q[ar_pi]   <= ar_id_i;
      ar_addr_q[ar_pi] <= ar_addr_i;
      ar_len_q[ar_pi]  <= ar_len_i;
    end
  end

  axi_trk_evq #(
    .DEPTH (EVQ_DEPTH)
  ) u_evq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push0_i (wr_ev),
    .rec0_i  (wr_rec),
    .push1_i (rd_ev),
    .rec1_i  (rd_rec),
    .pop_i   (ev_ready_i),
    .valid_o (ev_valid_o),
    .rec_o   (head_rec),
    .drop0_o (drop0),
    .drop1_o (drop1)
  );

  // Output mapping from the queue head and status registers.
  always_comb begin
    ev_kind_o       = head_rec.kind;
    ev_id_o         = head_rec.id[ID_WIDTH-1:0];
    ev_addr_o       = head_rec.addr[ADDR_WIDTH-1:0];
    ev_beats_o      = head_rec.beats;
    ev_resp_o       = head_rec.resp;
    err_o           = err_q;
    wr_cnt_o        = wr_cnt_q;
    rd_cnt_o        = rd_cnt_q;
    unused_rec_bits = ^{head_rec.id, head_rec.addr};
  end

endmodule

// File: tb/tb_axi_slave_txn_tracker.sv
// Directed self-checking bench for the AXI slave transaction tracker.
module tb_axi_slave_txn_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_i;
  logic        aw_valid_i, aw_ready_i;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [3:0]  aw_id_i;
  logic        w_valid_i, w_ready_i, w_last_i;
  logic        b_valid_i, b_ready_i;
  logic [3:0]  b_id_i;
  logic [1:0]  b_resp_i;
  logic        ar_valid_i, ar_ready_i;
  logic [31:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [3:0]  ar_id_i;
  logic        r_valid_i, r_ready_i, r_last_i;
  logic [3:0]  r_id_i;
  logic [1:0]  r_resp_i;
  logic        ev_valid_o, ev_ready_i;
  logic [1:0]  ev_kind_o;
  logic [3:0]  ev_id_o;
  logic [31:0] ev_addr_o;
  logic [8:0]  ev_beats_o;
  logic [1:0]  ev_resp_o;
  logic [5:0]  err_o;
  logic [15:0] wr_cnt_o, rd_cnt_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  axi_slave_txn_tracker #(
    .ADDR_WIDTH  (32),
    .ID_WIDTH    (4),
    .OUTSTANDING (4),
    .EVQ_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear_i),
    .aw_valid_i (aw_valid_i),
    .aw_ready_i (aw_ready_i),
    .aw_addr_i  (aw_addr_i),
    .aw_len_i   (aw_len_i),
    .aw_id_i    (aw_id_i),
    .w_valid_i  (w_valid_i),
    .w_ready_i  (w_ready_i),
    .w_last_i   (w_last_i),
    .b_valid_i  (b_valid_i),
    .b_ready_i  (b_ready_i),
    .b_id_i     (b_id_i),
    .b_resp_i   (b_resp_i),
    .ar_valid_i (ar_valid_i),
    .ar_ready_i (ar_ready_i),
    .ar_addr_i  (ar_addr_i),
    .ar_len_i   (ar_len_i),
    .ar_id_i    (ar_id_i),
    .r_valid_i  (r_valid_i),
    .r_ready_i  (r_ready_i),
    .r_last_i   (r_last_i),
    .r_id_i     (r_id_i),
    .r_resp_i   (r_resp_i),
    .ev_valid_o (ev_valid_o),
    .ev_ready_i (ev_ready_i),
    .ev_kind_o  (ev_kind_o),
    .ev_id_o    (ev_id_o),
    .ev_addr_o  (ev_addr_o),
    .ev_beats_o (ev_beats_o),
    .ev_resp_o  (ev_resp_o),
    .err_o      (err_o),
    .wr_cnt_o   (wr_cnt_o),
    .rd_cnt_o   (rd_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_i = 0; ev_ready_i = 0;
    aw_valid_i = 0; aw_ready_i = 0; aw_addr_i = '0; aw_len_i = '0; aw_id_i = '0;
    w_valid_i = 0; w_ready_i = 0; w_last_i = 0;
    b_valid_i = 0; b_ready_i = 0; b_id_i = '0; b_resp_i = '0;
    ar_valid_i = 0; ar_ready_i = 0; ar_addr_i = '0; ar_len_i = '0; ar_id_i = '0;
    r_valid_i = 0; r_ready_i = 0; r_last_i = 0; r_id_i = '0; r_resp_i = '0;
  endtask

  task automatic aw(input logic [3:0] id, input logic [7:0] len, input logic [31:0] addr);
    aw_valid_i = 1; aw_ready_i = 1; aw_id_i = id; aw_len_i = len; aw_addr_i = addr;
    cyc();
    aw_valid_i = 0; aw_ready_i = 0;
  endtask

  task automatic w(input logic last);
    w_valid_i = 1; w_ready_i = 1; w_last_i = last;
    cyc();
    w_valid_i = 0; w_ready_i = 0; w_last_i = 0;
  endtask

  task automatic b(input logic [3:0] id, input logic [1:0] resp);
    b_valid_i = 1; b_ready_i = 1; b_id_i = id; b_resp_i = resp;
    cyc();
    b_valid_i = 0; b_ready_i = 0;
  endtask

  task automatic ar(input logic [3:0] id, input logic [7:0] len, input logic [31:0] addr);
    ar_valid_i = 1; ar_ready_i = 1; ar_id_i = id; ar_len_i = len; ar_addr_i = addr;
    cyc();
    ar_valid_i = 0; ar_ready_i = 0;
  endtask

  task automatic r(input logic [3:0] id, input logic [1:0] resp, input logic last);
    r_valid_i = 1; r_ready_i = 1; r_id_i = id; r_resp_i = resp; r_last_i = last;
    cyc();
    r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
  endtask

  task automatic pop();
    ev_ready_i = 1;
    cyc();
    ev_ready_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 0;
    repeat (3) cyc();
    chk("rst_ev_valid", ev_valid_o, 0);
    chk("rst_ev_kind", ev_kind_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_wr_cnt", wr_cnt_o, 0);
    chk("rst_rd_cnt", rd_cnt_o, 0);
    rst_n = 1;
    cyc();

    // basic write burst
    aw(4'd3, 8'd3, 32'h1000);
    w(0); w(0); w(0); w(1);
    b(4'd3, 2'd0);
    chk("wr_valid", ev_valid_o, 1);
    chk("wr_kind", ev_kind_o, 1);
    chk("wr_id", ev_id_o, 3);
    chk("wr_addr", ev_addr_o, 32'h1000);
    chk("wr_beats", ev_beats_o, 4);
    chk("wr_resp", ev_resp_o, 0);
    chk("wr_cnt1", wr_cnt_o, 1);
    chk("wr_err", err_o, 0);
    pop();
    chk("wr_drained", ev_valid_o, 0);

    // basic read burst, resp is max over beats
    ar(4'd5, 8'd1, 32'h2000);
    r(4'd5, 2'd0, 0);
    r(4'd5, 2'd2, 1);
    chk("rd_kind", ev_kind_o, 2);
    chk("rd_id", ev_id_o, 5);
    chk("rd_addr", ev_addr_o, 32'h2000);
    chk("rd_beats", ev_beats_o, 2);
    chk("rd_resp", ev_resp_o, 2);
    chk("rd_cnt1", rd_cnt_o, 1);
    chk("rd_err", err_o, 0);
    pop();

    // early w_last -> W_LAST; wrong R id -> R_ID; then clear
    aw(4'd1, 8'd2, 32'h3000);
    w(0); w(1);
    chk("wlast_err", err_o, 6'h01);
    w(1);
    b(4'd1, 2'd0);
    chk("wlast_ev_beats", ev_beats_o, 3);
    chk("wlast_err_hold", err_o, 6'h01);
    chk("wr_cnt2", wr_cnt_o, 2);
    pop();
    ar(4'd5, 8'd0, 32'h4000);
    r(4'd6, 2'd1, 1);
    chk("rid_err", err_o, 6'h09);
    chk("rid_ev_resp", ev_resp_o, 1);
    chk("rd_cnt2", rd_cnt_o, 2);
    pop();
    clear_i = 1;
    cyc();
    clear_i = 0;
    chk("clr_err", err_o, 0);
    chk("clr_wr_cnt", wr_cnt_o, 0);
    chk("clr_rd_cnt", rd_cnt_o, 0);

    // B and final R in one cycle, consumer stalled
    aw(4'd2, 8'd0, 32'h5000);
    w(1);
    ar(4'd7, 8'd0, 32'h6000);
    b_valid_i = 1; b_ready_i = 1; b_id_i = 4'd2; b_resp_i = 2'd1;
    r_valid_i = 1; r_ready_i = 1; r_id_i = 4'd7; r_resp_i = 2'd0; r_last_i = 1;
    cyc();
    idle();
    chk("dual_first_kind", ev_kind_o, 1);
    chk("dual_first_id", ev_id_o, 2);
    chk("dual_first_resp", ev_resp_o, 1);
    cyc();
    chk("dual_stall_kind", ev_kind_o, 1);
    pop();
    chk("dual_second_kind", ev_kind_o, 2);
    chk("dual_second_id", ev_id_o, 7);
    chk("dual_second_addr", ev_addr_o, 32'h6000);
    pop();
    chk("dual_drained", ev_valid_o, 0);
    chk("dual_cnts", {wr_cnt_o, rd_cnt_o}, {16'd1, 16'd1});
    chk("dual_err", err_o, 0);

    // AR queue overflow: fifth AR dropped
    for (int i = 1; i <= 4; i++) ar(4'(i), 8'd0, 32'h7000 + 32'(i));
    chk("arq_full_err", err_o, 0);
    ar(4'd5, 8'd0, 32'h7005);
    chk("arq_ovf_err", err_o, 6'h20);
    for (int i = 1; i <= 4; i++) r(4'(i), 2'd0, 1);
    chk("arq_rd_cnt", rd_cnt_o, 5);
    chk("arq_head_id", ev_id_o, 1);
    chk("arq_head_addr", ev_addr_o, 32'h7001);
    r(4'd5, 2'd0, 1);
    chk("arq_dropped_err", err_o, 6'h28);
    chk("arq_dropped_cnt", rd_cnt_o, 5);
    ev_ready_i = 1;
    repeat (4) cyc();
    ev_ready_i = 0;
    chk("arq_drained", ev_valid_o, 0);
    clear_i = 1;
    cyc();
    clear_i = 0;

    // event queue overflow: ninth event dropped, counter still counts
    for (int i = 0; i < 8; i++) begin
      aw(4'(i), 8'd0, 32'hA000 + 32'(i) * 32'h10);
      w(1);
      b(4'(i), 2'd0);
    end
    chk("evq_full_err", err_o, 0);
    chk("evq_full_cnt", wr_cnt_o, 8);
    aw(4'd8, 8'd0, 32'hA080);
    w(1);
    b(4'd8, 2'd0);
    chk("evq_ovf_err", err_o, 6'h20);
    chk("evq_ovf_cnt", wr_cnt_o, 9);
    for (int i = 0; i < 8; i++) begin
      chk("evq_order_id", ev_id_o, 64'(i));
      pop();
    end
    chk("evq_ninth_dropped", ev_valid_o, 0);

    // reset mid write burst, then a fresh burst
    aw(4'd4, 8'd3, 32'h8000);
    w(0); w(0);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_cnt", wr_cnt_o, 0);
    #2 rst_n = 1;
    aw(4'd9, 8'd1, 32'h9000);
    w(0); w(1);
    b(4'd9, 2'd0);
    chk("post_rst_kind", ev_kind_o, 1);
    chk("post_rst_id", ev_id_o, 9);
    chk("post_rst_addr", ev_addr_o, 32'h9000);
    chk("post_rst_beats", ev_beats_o, 2);
    chk("post_rst_err", err_o, 0);
    chk("post_rst_cnt", wr_cnt_o, 1);
    pop();
    chk("post_rst_single", ev_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
